bc_timing_control: RTL and testbench
====================================

// Module: bc_timing_control
// PURPOSE
//   Timing/control sequencer for the basic computer: the start/stop flip-flop S, the sequence counter SC and the T-state sequencing.
//   Runs fetch (T0-T1), decode (T2), optional indirect (T3) and execute (T3+) using an instance of the 3-to-8 opcode decoder.
//   Issues register-transfer strobes to AR/PC/IR/memory and hands execute phases to the execution unit through a go/done handshake.
// PARAMETERS
//   SC_WIDTH     4  sequence counter width; SC saturates at 2**SC_WIDTH-1
//   USE_MEM_ACK  1  1: memory reads stall until mem_ack; 0: mem_ack ignored, reads complete in 1 cycle
// PORTS
//   clk         in   1         system clock, rising edge
//   rst_n       in   1         asynchronous active-low reset
//   start       in   1         set S (begin fetching) when idle
//   ir_op       in   3         IR[14:12] opcode field
//   ir_i        in   1         IR[15] indirect bit
//   ir_b0       in   1         IR[0]; HLT when register-reference
//   mem_ack     in   1         memory read data valid this cycle
//   exec_done   in   1         execution unit finished current instruction
//   s_flag      out  1         running (S flip-flop)
//   sc          out  SC_WIDTH  sequence counter value
//   t           out  8         one-hot T0..T7 from sc (all 0 when sc>7 or S=0)
//   d           out  8         latched one-hot opcode D0..D7
//   i_flag      out  1         latched indirect bit
//   ar_ld_pc    out  1         AR <- PC
//   mem_rd      out  1         memory read request
//   ir_ld       out  1         IR <- M[AR]
//   pc_inc      out  1         PC <- PC+1
//   ar_ld_ir    out  1         AR <- IR[11:0]
//   ar_ld_mem   out  1         AR <- M[AR] (indirect)
//   exec_go     out  1         one-cycle pulse: execute phase begins
//   sc_ovf      out  1         sticky: SC saturated without exec_done
// BEHAVIOUR
//   Reset (async, rst_n=0): S=0, sc=0, d=0, i_flag=0, sc_ovf=0, FSM=IDLE; all strobes 0. Reset mid-instruction aborts it.
//   FSM states: IDLE, F0, F1, DEC, IND, EXE. sc counts the cycles: 0 in F0, 1 in F1, 2 in DEC, 3 in IND or EXE entry, then +1 per cycle.
//   IDLE: S=0, sc=0. start=1 -> S=1, sc=0, next F0. start while S=1 is ignored.
//   F0 (T0): ar_ld_pc=1 for exactly 1 cycle -> F1.
//   F1 (T1): mem_rd=1. Stall in F1 with sc held at 1 until mem_ack=1 (or immediately if USE_MEM_ACK=0).
//     In the completing cycle, ir_ld=1 and pc_inc=1; these are combinational on mem_ack and pulse once. Next state DEC.
//   DEC (T2): d<=onehot(ir_op) from the decoder sub-module; i_flag<=ir_i; ar_ld_ir=1.
//     Next state is IND if ir_op!=7 and ir_i=1; otherwise EXE.
//   IND (T3): mem_rd=1; stall until mem_ack as in F1. Completing cycle: ar_ld_mem=1 -> EXE, sc=4.
//   EXE: exec_go=1 on the entry cycle only. sc increments every cycle so the execution unit sees successive T.
//     exec_done=1 -> sc=0 -> F0.
//   HLT: in EXE with d[7]=1, i_flag=0, ir_b0=1 -> S=0 -> IDLE at the same edge as exec_done. HLT without exec_done takes effect anyway.
//   Saturation: sc stops at all-ones. If EXE reaches all-ones without exec_done, sc_ovf=1 (sticky until reset); the FSM keeps waiting.
//   Simultaneous events:
//     - exec_done on the exec_go cycle is legal (1-cycle execute).
//     - mem_ack outside F1/IND is ignored.
//     - exec_done outside EXE is ignored.
//   t/d outputs are registered-state decodes; there is no combinational path from inputs to t/d.
// STRUCTURE
//   Shared package bc_pkg: FSM state localparams; opcode constants OP_AND..OP_REG(7); T index constants T0..T7.
//   Sub-module bc_dec3to8 (3-to-8 one-hot decoder) is instantiated twice: ir_op->d_next, and sc[2:0]->t (gated by sc<8 && S).
//   Everything else stays in this module: S flag, counter, FSM and strobe logic.
// TESTING
//   1. Reset, start=1 for 1 cycle, mem_ack tied 1, ir_op=2, ir_i=0, exec_done at sc=5
//      -> strobes at sc=0/1/2: ar_ld_pc, ir_ld+pc_inc, ar_ld_ir; exec_go at sc=3; d=8'h04; sc back to 0 after done.
//   2. ir_op=1, ir_i=1, mem_ack delayed 3 cycles in F1 and in IND
//      -> sc held at 1 then 3 during the stalls; ir_ld/ar_ld_mem pulse once each; exec_go at sc=4; i_flag=1.
//   3. ir_op=7, ir_i=0, ir_b0=1, exec_done at T3 -> d=8'h80, S=0, FSM IDLE, t=0; a later start=1 restarts at T0.
//   4. SC_WIDTH=4, exec_done never asserted -> sc saturates at 15, sc_ovf=1 and stays 1 through further cycles.
//   5. rst_n=0 asynchronously mid-IND -> all outputs 0 before the next clk edge; start during S=1 has no effect.
//   6. USE_MEM_ACK=0, back-to-back instructions with exec_done at T3 -> each instruction takes 4 cycles, T0 follows done.

Source files
------------

// File: rtl/bc_pkg.sv
// ---------------------------------------------------------------------------
// bc_pkg
//   Shared definitions for the basic-computer timing/control slice.
//   Contents:
//     bc_state_e       sequencer FSM states
//     OP_AND..OP_REG   3-bit opcode field values; OP_REG (7) marks a
//                      register-reference or I/O instruction
//     T0..T7           indices into the one-hot timing vector
//     is_hlt()         HLT detect from the latched decode, the latched
//                      indirect bit and IR[0]
// ---------------------------------------------------------------------------
package bc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_F0   = 3'd1,
        ST_F1   = 3'd2,
        ST_DEC  = 3'd3,
        ST_IND  = 3'd4,
        ST_EXE  = 3'd5
    } bc_state_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int T0 = 0;
    localparam int T1 = 1;
    localparam int T2 = 2;
    localparam int T3 = 3;
    localparam int T4 = 4;
    localparam int T5 = 5;
    localparam int T6 = 6;
    localparam int T7 = 7;

    // HLT is the register-reference instruction (D7, I=0) with IR[0] set.
    function automatic logic is_hlt(input logic [7:0] d, input logic i, input logic b0);
        return d[OP_REG] & ~i & b0;
    endfunction

endpackage

// File: rtl/bc_dec3to8.sv
// ---------------------------------------------------------------------------
// bc_dec3to8
//   3-to-8 one-hot decoder with enable. Used once for the opcode field and
//   once for the timing signals.
//   Ports:
//     sel_i  [2:0]  binary select
//     en_i          enable; output all zero when low
//     y_o    [7:0]  one-hot result
// ---------------------------------------------------------------------------
module bc_dec3to8 (
    input  logic [2:0] sel_i,
    input  logic       en_i,
    output logic [7:0] y_o
);

    always_comb begin
        y_o = '0;
        if (en_i) begin
            y_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/bc_timing_control.sv
// ---------------------------------------------------------------------------
// bc_timing_control
//   Timing and control sequencer for the basic computer: start/stop flag S,
//   sequence counter SC and the fetch / decode / indirect / execute walk.
//   Issues the register-transfer strobes for AR, PC, IR and memory, and
//   hands the execute phase to the execution unit with exec_go/exec_done.
//
//   Parameters:
//     SC_WIDTH     sequence counter width; SC saturates at all-ones
//     USE_MEM_ACK  1: memory reads wait for mem_ack, 0: reads take 1 cycle
//
//   Ports:
//     clk, rst_n        clock (rising edge), async active-low reset
//     start             set S and begin fetching when idle
//     ir_op, ir_i       IR[14:12] opcode, IR[15] indirect bit
//     ir_b0             IR[0] (HLT select for register-reference)
//     mem_ack           memory read data valid this cycle
//     exec_done         execution unit finished the instruction
//     s_flag, sc        running flag, sequence counter
//     t                 one-hot T0..T7 (zero when idle or sc > 7)
//     d, i_flag         latched opcode decode and indirect bit
//     ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem
//                       register-transfer strobes
//     exec_go           one-cycle pulse on entry to execute
//     sc_ovf            sticky: SC saturated in execute without exec_done
// ---------------------------------------------------------------------------
module bc_timing_control
    import bc_pkg::*;
#(
    parameter int SC_WIDTH    = 4,
    parameter bit USE_MEM_ACK = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [2:0]          ir_op,
    input  logic                ir_i,
    input  logic                ir_b0,
    input  logic                mem_ack,
    input  logic                exec_done,
    output logic                s_flag,
    output logic [SC_WIDTH-1:0] sc,
    output logic [7:0]          t,
    output logic [7:0]          d,
    output logic                i_flag,
    output logic                ar_ld_pc,
    output logic                mem_rd,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                ar_ld_ir,
    output logic                ar_ld_mem,
    output logic                exec_go,
    output logic                sc_ovf
);

    localparam logic [SC_WIDTH-1:0] SC_MAX = '1;

    bc_state_e             state_q, state_d;
    logic                  s_q, s_d;
    logic [SC_WIDTH-1:0]   sc_q, sc_d;
    logic [7:0]            d_q, d_d;
    logic                  i_q, i_d;
    logic                  ovf_q, ovf_d;
    logic                  go_q, go_d;

    logic [7:0]            d_next;
    logic [SC_WIDTH-1:0]   sc_inc;
    logic                  rd_ack;
    logic                  t_en;

    // Without handshake every read is treated as completing immediately.
    assign rd_ack = USE_MEM_ACK ? mem_ack : 1'b1;

    // Saturating increment: the counter parks at all-ones.
    assign sc_inc = (sc_q == SC_MAX) ? sc_q : sc_q + 1'b1;

    // Opcode decode feeds the D latch in DEC.
    bc_dec3to8 u_dec_op (
        .sel_i (ir_op),
        .en_i  (1'b1),
        .y_o   (d_next)
    );

    // Timing decode works from registered sc/S only, so t never depends
    // combinationally on inputs. Counts above 7 have no T line.
    assign t_en = s_q & (32'(sc_q) < 32'd8);

    bc_dec3to8 u_dec_t (
        .sel_i (sc_q[2:0]),
        .en_i  (t_en),
        .y_o   (t)
    );

    // -----------------------------------------------------------------------
    // Next-state and strobe logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        sc_d      = sc_q;
        d_d       = d_q;
        i_d       = i_q;
        ovf_d     = ovf_q;
        ar_ld_pc  = 1'b0;
        mem_rd    = 1'b0;
        ir_ld     = 1'b0;
        pc_inc    = 1'b0;
        ar_ld_ir  = 1'b0;
        ar_ld_mem = 1'b0;
        exec_go   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                s_d  = 1'b0;
                sc_d = '0;
                if (start) begin
                    s_d     = 1'b1;
                    state_d = ST_F0;
                end
            end

            ST_F0: begin
                ar_ld_pc = 1'b1;
                sc_d     = sc_inc;
                state_d  = ST_F1;
            end

            // Stall with sc held until the read returns; the load strobes
            // fire only in the completing cycle.
            ST_F1: begin
                mem_rd = 1'b1;
                if (rd_ack) begin
                    ir_ld   = 1'b1;
                    pc_inc  = 1'b1;
                    sc_d    = sc_inc;
                    state_d = ST_DEC;
                end
            end

            // Register-reference / I/O (opcode 7) reuses IR[15] as a class
            // bit, so it never goes indirect.
            ST_DEC: begin
                ar_ld_ir = 1'b1;
                d_d      = d_next;
                i_d      = ir_i;
                sc_d     = sc_inc;
                state_d  = (ir_op != OP_REG && ir_i) ? ST_IND : ST_EXE;
            end

            ST_IND: begin
                mem_rd = 1'b1;
                if (rd_ack) begin
                    ar_ld_mem = 1'b1;
                    sc_d      = sc_inc;
                    state_d   = ST_EXE;
                end
            end

            // HLT wins over exec_done: both clear sc, but HLT also drops S.
            ST_EXE: begin
                exec_go = go_q;
                if (is_hlt(d_q, i_q, ir_b0)) begin
                    s_d     = 1'b0;
                    sc_d    = '0;
                    state_d = ST_IDLE;
                end else if (exec_done) begin
                    sc_d    = '0;
                    state_d = ST_F0;
                end else begin
                    sc_d = sc_inc;
                    if (sc_q == SC_MAX) begin
                        ovf_d = 1'b1;
                    end
                end
            end

            default: begin
                s_d     = 1'b0;
                sc_d    = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // exec_go marks the first EXE cycle; flag it on the transition in.
    assign go_d = (state_d == ST_EXE) && (state_q != ST_EXE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            s_q     <= 1'b0;
            sc_q    <= '0;
            d_q     <= '0;
            i_q     <= 1'b0;
            ovf_q   <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            sc_q    <= sc_d;
            d_q     <= d_d;
            i_q     <= i_d;
            ovf_q   <= ovf_d;
            go_q    <= go_d;
        end
    end

    assign s_flag = s_q;
    assign sc     = sc_q;
    assign d      = d_q;
    assign i_flag = i_q;
    assign sc_ovf = ovf_q;

endmodule

// File: tb/tb_bc_timing_control.sv
module tb_bc_timing_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, ack, done, ii, b0;
    logic [2:0] op;

    logic       s_flag, i_flag, ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, exec_go, sc_ovf;
    logic [3:0] sc;
    logic [7:0] t, d;
    logic [6:0] stb;

    // second instance: no memory handshake
    logic       start0, ack0, done0;
    logic       s0, i0, alp0, rd0, irl0, inc0, ari0, arm0, go0, ovf0;
    logic [3:0] sc0;
    logic [7:0] t0, d0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bc_timing_control #(.SC_WIDTH(4), .USE_MEM_ACK(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir_op(op), .ir_i(ii), .ir_b0(b0),
        .mem_ack(ack), .exec_done(done), .s_flag(s_flag), .sc(sc), .t(t), .d(d),
        .i_flag(i_flag), .ar_ld_pc(ar_ld_pc), .mem_rd(mem_rd), .ir_ld(ir_ld),
        .pc_inc(pc_inc), .ar_ld_ir(ar_ld_ir), .ar_ld_mem(ar_ld_mem),
        .exec_go(exec_go), .sc_ovf(sc_ovf)
    );

    bc_timing_control #(.SC_WIDTH(4), .USE_MEM_ACK(1'b0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .ir_op(op), .ir_i(ii), .ir_b0(b0),
        .mem_ack(ack0), .exec_done(done0), .s_flag(s0), .sc(sc0), .t(t0), .d(d0),
        .i_flag(i0), .ar_ld_pc(alp0), .mem_rd(rd0), .ir_ld(irl0),
        .pc_inc(inc0), .ar_ld_ir(ari0), .ar_ld_mem(arm0),
        .exec_go(go0), .sc_ovf(ovf0)
    );

    assign stb = {ar_ld_pc, mem_rd, ir_ld, pc_inc, ar_ld_ir, ar_ld_mem, exec_go};

    localparam logic [6:0] PC  = 7'b1000000;
    localparam logic [6:0] RD  = 7'b0100000;
    localparam logic [6:0] IRL = 7'b0010000;
    localparam logic [6:0] INC = 7'b0001000;
    localparam logic [6:0] ARI = 7'b0000100;
    localparam logic [6:0] ARM = 7'b0000010;
    localparam logic [6:0] GO  = 7'b0000001;

    typedef struct {
        logic       start, ack, done;
        logic [2:0] op;
        logic       ii, b0;
        logic       s;
        logic [3:0] sc;
        logic [7:0] t, d;
        logic       ifl;
        logic [6:0] stb;
    } vec_t;

    vec_t tbl[25];

    function automatic vec_t mk(input logic st, input logic ak, input logic dn, input logic [2:0] o,
                                input logic i, input logic b, input logic s, input logic [3:0] c,
                                input logic [7:0] tt, input logic [7:0] dd, input logic f, input logic [6:0] sb);
        vec_t v;
        v.start = st; v.ack = ak; v.done = dn; v.op = o; v.ii = i; v.b0 = b;
        v.s = s; v.sc = c; v.t = tt; v.d = dd; v.ifl = f; v.stb = sb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit found;
        // inputs / expected outputs per cycle
        // 1: LDA direct, exec_done at T5
        tbl[0]  = mk(1,1,0,3'd2,0,0, 0,4'd0,8'h00,8'h00,0,7'b0);
        tbl[1]  = mk(0,1,0,3'd2,0,0, 1,4'd0,8'h01,8'h00,0,PC);
        tbl[2]  = mk(0,1,0,3'd2,0,0, 1,4'd1,8'h02,8'h00,0,RD|IRL|INC);
        tbl[3]  = mk(0,1,0,3'd2,0,0, 1,4'd2,8'h04,8'h00,0,ARI);
        tbl[4]  = mk(0,1,0,3'd2,0,0, 1,4'd3,8'h08,8'h04,0,GO);
        tbl[5]  = mk(0,1,0,3'd2,0,0, 1,4'd4,8'h10,8'h04,0,7'b0);
        tbl[6]  = mk(0,1,1,3'd2,0,0, 1,4'd5,8'h20,8'h04,0,7'b0);
        // 2: ADD indirect, 3-cycle ack delay in F1 and IND, 1-cycle execute
        tbl[7]  = mk(0,0,0,3'd1,1,0, 1,4'd0,8'h01,8'h04,0,PC);
        tbl[8]  = mk(0,0,0,3'd1,1,0, 1,4'd1,8'h02,8'h04,0,RD);
        tbl[9]  = mk(0,0,0,3'd1,1,0, 1,4'd1,8'h02,8'h04,0,RD);
        tbl[10] = mk(0,0,0,3'd1,1,0, 1,4'd1,8'h02,8'h04,0,RD);
        tbl[11] = mk(0,1,0,3'd1,1,0, 1,4'd1,8'h02,8'h04,0,RD|IRL|INC);
        tbl[12] = mk(0,0,0,3'd1,1,0, 1,4'd2,8'h04,8'h04,0,ARI);
        tbl[13] = mk(0,0,0,3'd1,1,0, 1,4'd3,8'h08,8'h02,1,RD);
        tbl[14] = mk(0,0,0,3'd1,1,0, 1,4'd3,8'h08,8'h02,1,RD);
        tbl[15] = mk(0,0,0,3'd1,1,0, 1,4'd3,8'h08,8'h02,1,RD);
        tbl[16] = mk(0,1,0,3'd1,1,0, 1,4'd3,8'h08,8'h02,1,RD|ARM);
        tbl[17] = mk(0,1,1,3'd1,1,0, 1,4'd4,8'h10,8'h02,1,GO);
        // 3: HLT (op 7, I=0, b0=1) with exec_done at T3, then restart
        tbl[18] = mk(0,1,0,3'd7,0,1, 1,4'd0,8'h01,8'h02,1,PC);
        tbl[19] = mk(0,1,0,3'd7,0,1, 1,4'd1,8'h02,8'h02,1,RD|IRL|INC);
        tbl[20] = mk(0,1,0,3'd7,0,1, 1,4'd2,8'h04,8'h02,1,ARI);
        tbl[21] = mk(0,1,1,3'd7,0,1, 1,4'd3,8'h08,8'h80,0,GO);
        tbl[22] = mk(0,1,1,3'd7,0,1, 0,4'd0,8'h00,8'h80,0,7'b0);
        tbl[23] = mk(1,0,0,3'd0,0,0, 0,4'd0,8'h00,8'h80,0,7'b0);
        tbl[24] = mk(0,1,0,3'd0,0,0, 1,4'd0,8'h01,8'h80,0,PC);

        rst_n = 1'b0; start = 0; ack = 0; done = 0; op = 0; ii = 0; b0 = 0;
        start0 = 0; ack0 = 0; done0 = 0;
        @(negedge clk);
        #1;
        chk("rst_s",   32'(s_flag), 0);
        chk("rst_sc",  32'(sc), 0);
        chk("rst_t",   32'(t), 0);
        chk("rst_d",   32'(d), 0);
        chk("rst_i",   32'(i_flag), 0);
        chk("rst_stb", 32'(stb), 0);
        chk("rst_ovf", 32'(sc_ovf), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int r = 0; r < 25; r++) begin
            @(negedge clk);
            start = tbl[r].start; ack = tbl[r].ack; done = tbl[r].done;
            op = tbl[r].op; ii = tbl[r].ii; b0 = tbl[r].b0;
            #1;
            chk($sformatf("row%0d_s", r),   32'(s_flag), 32'(tbl[r].s));
            chk($sformatf("row%0d_sc", r),  32'(sc),     32'(tbl[r].sc));
            chk($sformatf("row%0d_t", r),   32'(t),      32'(tbl[r].t));
            chk($sformatf("row%0d_d", r),   32'(d),      32'(tbl[r].d));
            chk($sformatf("row%0d_i", r),   32'(i_flag), 32'(tbl[r].ifl));
            chk($sformatf("row%0d_stb", r), 32'(stb),    32'(tbl[r].stb));
        end

        // 4: saturation -- AND direct, exec_done never comes
        start = 0; ack = 1; done = 0; op = 0; ii = 0; b0 = 0;
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            #1;
            if (sc == 4'd15) begin
                found = 1'b1;
                break;
            end
        end
        chk("sat_reach", 32'(found), 1);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            start = (n == 1);   // ignored while S=1
            #1;
            chk($sformatf("sat%0d_sc", n),  32'(sc), 15);
            chk($sformatf("sat%0d_t", n),   32'(t), 0);
            chk($sformatf("sat%0d_s", n),   32'(s_flag), 1);
            chk($sformatf("sat%0d_stb", n), 32'(stb), 0);
            if (n > 0) chk($sformatf("sat%0d_ovf", n), 32'(sc_ovf), 1);
        end
        start = 0;

        // 5: reset clears ovf; async reset in the middle of IND
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst2_ovf", 32'(sc_ovf), 0);
        chk("rst2_sc",  32'(sc), 0);
        @(negedge clk);
        rst_n = 1'b1; start = 1; op = 3'd0; ii = 1; b0 = 0; ack = 1; done = 0;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        @(negedge clk);
        ack = 0;
        @(negedge clk);
        start = 1;
        #1;
        chk("ind_sc",  32'(sc), 3);
        chk("ind_stb", 32'(stb), 32'(RD));
        chk("ind_d",   32'(d), 32'h01);
        chk("ind_i",   32'(i_flag), 1);
        @(negedge clk);
        start = 0;
        #1;
        chk("ind_start_sc",  32'(sc), 3);
        chk("ind_start_stb", 32'(stb), 32'(RD));
        chk("ind_start_s",   32'(s_flag), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_s",   32'(s_flag), 0);
        chk("arst_sc",  32'(sc), 0);
        chk("arst_t",   32'(t), 0);
        chk("arst_d",   32'(d), 0);
        chk("arst_i",   32'(i_flag), 0);
        chk("arst_stb", 32'(stb), 0);
        chk("arst_ovf", 32'(sc_ovf), 0);

        // 6: no-handshake instance, back-to-back 4-cycle instructions
        @(negedge clk);
        rst_n = 1'b1; op = 3'd3; ii = 0; b0 = 0;
        start0 = 1; done0 = 1; ack0 = 0;
        @(negedge clk);
        start0 = 0;
        for (int k = 0; k < 12; k++) begin
            #1;
            chk($sformatf("nack%0d_sc", k), 32'(sc0), 32'(k % 4));
            chk($sformatf("nack%0d_t", k),  32'(t0),  32'(1) << (k % 4));
            chk($sformatf("nack%0d_go", k), 32'(go0), 32'((k % 4) == 3));
            chk($sformatf("nack%0d_ir", k), 32'(irl0), 32'((k % 4) == 1));
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
